// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: multi-cycle load-use stall, branch flush and dmem freeze control with perf counters
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 3,
  parameter int PERF_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic                  branch_taken,
  input  logic                  dmem_busy,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  pipe_freeze,
  output logic                  lu_active,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [PERF_W-1:0]     lu_stall_cycles,
  output logic [PERF_W-1:0]     flush_count
);
  localparam logic [0:0] RUN = 1'b0, LU_STALL = 1'b1;
  logic [0:0] st;
  logic [CNT_W-1:0] cnt;
  logic hz, lu_go;
  always_comb begin
    hz = ex_regwrite & ex_memread & (|ex_rd) &
         ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    // inside LU_STALL the bubble continues without re-checking hz
    lu_go = !dmem_busy & !branch_taken & ((st == LU_STALL) | hz);
    pc_stall = !rst & (dmem_busy | lu_go);
    ifid_stall = pc_stall;
    ifid_flush = !rst & !dmem_busy & branch_taken;
    idex_bubble = !rst & !dmem_busy & (branch_taken | lu_go);
    pipe_freeze = !rst & dmem_busy;
  end
  assign lu_active = (st == LU_STALL);
  assign stall_cnt = cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= RUN;
      cnt <= '0;
      lu_stall_cycles <= '0;
      flush_count <= '0;
    end else if (!dmem_busy) begin
      if (branch_taken) begin
        st <= RUN;
        cnt <= '0;
        flush_count <= &flush_count ? flush_count : flush_count + PERF_W'(1);
      end else if (lu_go) begin
        lu_stall_cycles <= &lu_stall_cycles ? lu_stall_cycles : lu_stall_cycles + PERF_W'(1);
        if (st == LU_STALL) begin
          st <= (cnt == CNT_W'(1)) ? RUN : LU_STALL;
          cnt <= cnt - CNT_W'(1);
        end else if (LOAD_LAT > 1) begin
          st <= LU_STALL;
          cnt <= CNT_W'(LOAD_LAT - 1);
        end
      end
    end
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Parametrised hazard control unit for the 5-stage pipeline, the successor to the single-bubble load-use detector. It supports configurable load-to-use latency (multi-cycle bubble via FSM/counter), branch flush with stall cancellation, and a data-memory busy freeze. It also keeps saturating performance counters. It sits between the ID/EX/MEM pipeline registers and the PC/IF-ID/ID-EX/EX-MEM register enables in sccomp.

Parameters:
REG_ADDR_W, 5, register index width
LOAD_LAT, 1, total stall cycles inserted per load-use hazard (legal 1..7)
CNT_W, 3, width of internal stall counter (must hold LOAD_LAT)
PERF_W, 16, width of performance counters

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
id_rs1  in  REG_ADDR_W  ID-stage source 1 index
id_rs2  in  REG_ADDR_W  ID-stage source 2 index
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  EX-stage destination
ex_regwrite  in  1  EX instruction writes rd
ex_memread  in  1  EX instruction is a load
branch_taken  in  1  EX resolved taken branch/jump
dmem_busy  in  1  data memory not ready this cycle
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  clear IF/ID to NOP
idex_bubble  out  1  load NOP into ID/EX
pipe_freeze  out  1  hold ID/EX and EX/MEM (memory wait)
lu_active  out  1  FSM in LU_STALL
stall_cnt  out  CNT_W  remaining stall cycles
lu_stall_cycles  out  PERF_W  count of load-use bubble cycles
flush_count  out  PERF_W  count of branch flushes

Behaviour:
- dep = (id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd); also require ex_rd != 0, ex_regwrite and ex_memread. Otherwise hz = 0. hz is computed from current inputs.
- FSM states: RUN, LU_STALL. Reset: RUN, stall_cnt=0, both counters 0. All outputs are 0 while rst is high.
- Priority per cycle: dmem_busy > branch_taken > load-use.
- dmem_busy=1:
  - pc_stall=ifid_stall=pipe_freeze=1; ifid_flush=idex_bubble=0.
  - State, stall_cnt and counters hold, regardless of branch_taken or hz.
- Otherwise, branch_taken=1:
  - ifid_flush=1, idex_bubble=1, pc_stall=ifid_stall=0.
  - flush_count++ (saturating).
  - Next state RUN, stall_cnt=0. This cancels any LU_STALL; hz is ignored.
- Otherwise, in RUN with hz=1:
  - pc_stall=ifid_stall=idex_bubble=1; lu_stall_cycles++ (saturating).
  - If LOAD_LAT==1, stay in RUN.
  - Else go to LU_STALL with stall_cnt=LOAD_LAT-1.
- Otherwise, in LU_STALL:
  - pc_stall=ifid_stall=idex_bubble=1; lu_stall_cycles++; stall_cnt decrements.
  - When stall_cnt==1 this cycle, next state is RUN and stall_cnt=0. hz is not re-evaluated inside LU_STALL.
- Otherwise all control outputs are 0.
- Each load-use hazard therefore inserts exactly LOAD_LAT bubble cycles, excluding frozen cycles.
- lu_active = (state==LU_STALL). Counters saturate at all-ones and do not wrap.
- Reset asserted mid-stall: immediate return to RUN, all outputs 0 asynchronously.

Test Plan:
- LOAD_LAT=1; lw x7 in EX (ex_memread=1, ex_rd=7); add uses rs1=x7 -> one cycle of pc_stall/ifid_stall/idex_bubble=1, lu_active stays 0, lu_stall_cycles=1.
- LOAD_LAT=3, same hazard -> bubbles on cycles 1,2,3; stall_cnt reads 2,1 on cycles 2,3; RUN with all outputs 0 on cycle 4; lu_stall_cycles=3.
- Load with ex_rd=0, or id_rs1_used=0 with rs1 matching -> no stall. A non-load writer (ex_memread=0) to x7 -> no stall.
- LOAD_LAT=3, branch_taken=1 on stall cycle 2 -> that cycle ifid_flush=idex_bubble=1, pc_stall=0; next cycle RUN; flush_count=1, lu_stall_cycles=1.
- LOAD_LAT=3, dmem_busy high for 2 cycles after stall cycle 1 -> pipe_freeze=1 both cycles, stall_cnt held at 2. Bubbles resume afterward; lu_stall_cycles=3 at end.
- Assert rst asynchronously mid-LU_STALL -> outputs 0 before the next edge; counters 0; after release, a fresh hazard behaves as in the first scenario.
